axis_skid_register: RTL

//  Parametrised AXI-Stream register slice with full-throughput skid buffer and frame counting.

---
 rtl/axis_pkg.sv | 14 +
 rtl/axis_frame_counter.sv | 65 ++++++
 rtl/axis_skid_register.sv | 122 ++++++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream register-slice family.
package axis_pkg;

    localparam int unsigned AXIS_DATA_W_DEF      = 8;
    localparam int unsigned AXIS_FRAME_CNT_W_DEF = 5;
    localparam int unsigned AXIS_BEAT_CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/axis_frame_counter.sv
// Counts completed frames leaving an AXIS stage; with AXIS_BEAT_CNT_EN also
// counts beats within the current frame (saturating).
module axis_frame_counter #(
    parameter int unsigned FRAME_CNT_W = 5
`ifdef AXIS_BEAT_CNT_EN
    ,parameter int unsigned BEAT_CNT_W = 8
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   out_hs,
    input  logic                   m_tlast,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef AXIS_BEAT_CNT_EN
    ,output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Frame counter wraps naturally at all-ones.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_hs && m_tlast) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

`ifdef AXIS_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Cleared by the closing beat of a frame, otherwise saturating increment.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_hs) begin
            if (m_tlast) begin
                beat_cnt_d = '0;
            end else if (beat_cnt_q != {BEAT_CNT_W{1'b1}}) begin
                beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: rtl/axis_skid_register.sv
// Full-throughput AXIS register slice with skid buffer and frame counting.
// Optional per-frame beat counter enabled by defining AXIS_BEAT_CNT_EN.
module axis_skid_register
    import axis_pkg::*;
#(
    parameter int unsigned DATA_W      = AXIS_DATA_W_DEF,
    parameter int unsigned FRAME_CNT_W = AXIS_FRAME_CNT_W_DEF
`ifdef AXIS_BEAT_CNT_EN
    ,parameter int unsigned BEAT_CNT_W = AXIS_BEAT_CNT_W_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [DATA_W-1:0]      m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef AXIS_BEAT_CNT_EN
    ,output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

    skid_state_t       state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_last_q, skid_last_d;
    logic              s_tready_q, s_tready_d;
    logic              in_hs;
    logic              out_hs;

    assign in_hs  = s_tvalid && s_tready_q;
    assign out_hs = out_valid_q && m_tready;

    // Next-state and datapath steering; skid register only fills when output stalls.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        unique case (state_q)
            EMPTY: begin
                if (in_hs) begin
                    out_data_d = s_tdata;
                    out_last_d = s_tlast;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    out_data_d = s_tdata;
                    out_last_d = s_tlast;
                end else if (in_hs) begin
                    skid_data_d = s_tdata;
                    skid_last_d = s_tlast;
                    state_d     = FULL;
                end else if (out_hs) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    out_data_d = skid_data_q;
                    out_last_d = skid_last_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
        s_tready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            s_tready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            s_tready_q  <= s_tready_d;
        end
    end

    assign s_tready = s_tready_q;
    assign m_tdata  = out_data_q;
    assign m_tvalid = out_valid_q;
    assign m_tlast  = out_last_q;

    axis_frame_counter #(
        .FRAME_CNT_W (FRAME_CNT_W)
`ifdef AXIS_BEAT_CNT_EN
        ,.BEAT_CNT_W (BEAT_CNT_W)
`endif
    ) u_frame_counter (
        .clk       (clk),
        .reset     (reset),
        .out_hs    (out_hs),
        .m_tlast   (out_last_q),
        .frame_cnt (frame_cnt)
`ifdef AXIS_BEAT_CNT_EN
        ,.beat_cnt (beat_cnt)
`endif
    );

endmodule
